// File: rtl/pl_pkg.sv
// Shared types and helpers for the generic pipeline-stage register.
// State encoding covers the optional skid build (PL_STAGE_SKID_EN).
package pl_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pl_state_t;

    // Replicated to CTRL_W bits by the users of the control slice.
    localparam logic PL_CTRL_RST_BIT = 1'b0;

    function automatic logic [63:0] PL_CNT_MAX(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/pl_stage_entry.sv
// One payload entry {ctrl, data}: load writes both slices, clear_ctrl resets
// only the control slice so flushed beats keep their data for debug.
module pl_stage_entry
    import pl_pkg::*;
#(
    parameter int                 CTRL_W   = 16,
    parameter int                 DATA_W   = 96,
    parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{PL_CTRL_RST_BIT}}
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // NOTE: the data slice is reset too, so out_data is a defined 0 after reset
    // rather than X; this is a register, not a RAM, so the reset is cheap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_ctrl <= CTRL_RST;
            q_data <= '0;
        end else begin
            if (clear_ctrl)
                q_ctrl <= CTRL_RST;
            else if (load)
                q_ctrl <= d_ctrl;
            if (load)
                q_data <= d_data;
        end
    end

endmodule

// File: rtl/pl_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flushable control slice.
// Define PL_STAGE_SKID_EN for a second (skid) entry and a registered in_ready.
module pl_stage_reg
    import pl_pkg::*;
#(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{PL_CTRL_RST_BIT}},
    parameter int                 CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PL_CNT_MAX(CNT_W));

    pl_state_t   state, state_nxt;
    logic        accept, emit, main_load;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign emit      = out_valid && out_ready;

`ifdef PL_STAGE_SKID_EN
    logic              skid_load;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Depends on state only, which cuts the out_ready -> in_ready path.
    assign in_ready    = !flush && (state != SKID);
    assign main_d_ctrl = (state == SKID) ? skid_ctrl : in_ctrl;
    assign main_d_data = (state == SKID) ? skid_data : in_data;

    pl_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CTRL_RST)) u_skid (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (skid_load),
        .clear_ctrl (flush),
        .d_ctrl     (in_ctrl),
        .d_data     (in_data),
        .q_ctrl     (skid_ctrl),
        .q_data     (skid_data)
    );
`else
    assign in_ready    = !flush && ((state == EMPTY) || out_ready);
    assign main_d_ctrl = in_ctrl;
    assign main_d_data = in_data;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= EMPTY;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
`ifdef PL_STAGE_SKID_EN
        skid_load = 1'b0;
`endif
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (emit && accept) begin
                        main_load = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
`ifdef PL_STAGE_SKID_EN
                    end else if (accept) begin
                        state_nxt = SKID;
                        skid_load = 1'b1;
`endif
                    end
                end
`ifdef PL_STAGE_SKID_EN
                SKID: begin
                    if (emit) begin
                        state_nxt = FULL;
                        main_load = 1'b1;
                    end
                end
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

    pl_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_RST(CTRL_RST)) u_main (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (main_load),
        .clear_ctrl (flush),
        .d_ctrl     (main_d_ctrl),
        .d_data     (main_d_data),
        .q_ctrl     (out_ctrl),
        .q_data     (out_data)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pl_stage_reg.sv
// Scoreboard bench for pl_stage_reg (default build or PL_STAGE_SKID_EN);
// a second instance with CNT_W=4 covers stall counter saturation.
module tb_pl_stage_reg;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [95:0] data;
    } beat_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic [95:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [15:0] out_ctrl;
    logic [95:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4;
    logic [15:0] out_ctrl4;
    logic [95:0] out_data4;
    logic [3:0]  stall_cnt4;

    int checks   = 0;
    int failures = 0;
    beat_t exp_q[$];

    always #5 CLK = ~CLK;

    pl_stage_reg dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pl_stage_reg #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
        .out_data(out_data4), .stall_cnt(stall_cnt4)
    );

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        exp_q.delete();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'h0 || stall_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b ctrl=%h data=%h cnt=%0d, want 0/0/0/0",
                     out_valid, out_ctrl, out_data, stall_cnt);
        end
        checks++;
        if (out_valid4 !== 1'b0 || out_ctrl4 !== 16'h0 || out_data4 !== 96'h0 || stall_cnt4 !== 4'h0) begin
            failures++;
            $display("FAIL reset_state4: valid=%b ctrl=%h data=%h cnt=%0d, want 0/0/0/0",
                     out_valid4, out_ctrl4, out_data4, stall_cnt4);
        end
        nRST = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b/%b, want 1/1", in_ready, in_ready4);
        end
    endtask

    // Drive one cycle of stimulus, check/pop an emitted beat, push an accepted one.
    task automatic drive_beat(input logic v, input logic [15:0] c, input logic [95:0] d,
                              input logic rdy, input logic exp_rdy, input string tag);
        beat_t exp_b;
        in_valid = v; in_ctrl = c; in_data = d; out_ready = rdy;
        #1;
        if (v) begin
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL %s_in_ready: got %b, want %b", tag, in_ready, exp_rdy);
            end
        end
        if (rdy && exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== exp_b.ctrl || out_data !== exp_b.data) begin
                failures++;
                $display("FAIL %s_emit: valid=%b ctrl=%h data=%h, want 1 ctrl=%h data=%h",
                         tag, out_valid, out_ctrl, out_data, exp_b.ctrl, exp_b.data);
            end
        end
        if (v && exp_rdy) exp_q.push_back('{ctrl: c, data: d});
        cycle();
    endtask

    task automatic test_stream();
        test_reset();
        for (int i = 0; i < 8; i++)
            drive_beat(1'b1, 16'(i), 96'(8'h10 + i), 1'b1, 1'b1, "stream");
        drive_beat(1'b0, '0, '0, 1'b1, 1'b1, "stream");
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stream_drain: valid=%b pending=%0d cnt=%0d, want 0/0/0",
                     out_valid, exp_q.size(), stall_cnt);
        end
    endtask

    task automatic test_stall_hold();
        logic exp_rdy;
        test_reset();
        drive_beat(1'b1, 16'h0003, 96'hAB, 1'b0, 1'b1, "stall");
`ifdef PL_STAGE_SKID_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL stall_in_ready: got %b, want %b", in_ready, exp_rdy);
        end
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== 16'h0003 || out_data !== 96'hAB || stall_cnt !== 16'(k)) begin
                failures++;
                $display("FAIL stall_hold_%0d: valid=%b ctrl=%h data=%h cnt=%0d, want 1 0003 ab %0d",
                         k, out_valid, out_ctrl, out_data, stall_cnt, k);
            end
        end
        drive_beat(1'b0, '0, '0, 1'b1, 1'b1, "stall");
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd5) begin
            failures++;
            $display("FAIL stall_release: valid=%b cnt=%0d, want 0 5", out_valid, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        drive_beat(1'b1, 16'h000A, 96'hA, 1'b0, 1'b1, "b2b");
`ifdef PL_STAGE_SKID_EN
        drive_beat(1'b1, 16'h000B, 96'hB, 1'b0, 1'b1, "b2b");
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 96'hA) begin
            failures++;
            $display("FAIL b2b_skid_full: in_ready=%b data=%h, want 0 a", in_ready, out_data);
        end
        drive_beat(1'b0, '0, '0, 1'b1, 1'b1, "b2b");
        drive_beat(1'b0, '0, '0, 1'b1, 1'b1, "b2b");
`else
        drive_beat(1'b1, 16'h000B, 96'hB, 1'b0, 1'b0, "b2b");
        drive_beat(1'b0, '0, '0, 1'b1, 1'b1, "b2b");
`endif
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b pending=%0d, want 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_flush();
        test_reset();
        drive_beat(1'b1, 16'hFFFF, 96'h1234, 1'b0, 1'b1, "flush");
        flush = 1'b1;
        drive_beat(1'b1, 16'h5555, 96'h9999, 1'b0, 1'b0, "flush");
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 96'h1234) begin
            failures++;
            $display("FAIL flush_state: valid=%b ctrl=%h data=%h, want 0 0000 1234",
                     out_valid, out_ctrl, out_data);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 96'h1234 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_no_accept: valid=%b data=%h in_ready=%b, want 0 1234 1",
                     out_valid, out_data, in_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_saturate();
        test_reset();
        drive_beat(1'b1, 16'h0001, 96'h77, 1'b0, 1'b1, "sat");
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 14 || k == 15 || k == 20) begin
                checks++;
                if (stall_cnt4 !== 4'(k > 15 ? 15 : k) || stall_cnt !== 16'(k)) begin
                    failures++;
                    $display("FAIL sat_cnt_%0d: got %0d/%0d, want %0d/%0d",
                             k, stall_cnt4, stall_cnt, (k > 15 ? 15 : k), k);
                end
            end
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        checks++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd21 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_after_flush: cnt4=%0d cnt=%0d valid=%b, want 15 21 0",
                     stall_cnt4, stall_cnt, out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        test_reset();
        drive_beat(1'b1, 16'h00C0, 96'hC0, 1'b0, 1'b1, "rmid");
        repeat (3) cycle();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || out_ctrl !== 16'h0 || out_data !== 96'h0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b cnt=%0d ctrl=%h data=%h, want all 0",
                     out_valid, stall_cnt, out_ctrl, out_data);
        end
        exp_q.delete();
        test_reset();
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        test_reset();
        test_stream();
        test_stall_hold();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
